// File: rtl/efuse_pkg.sv
// Shared mode codes, sequencer state encoding and a small parameter helper
// for the eFuse program/read sequencer.
package efuse_pkg;

    localparam logic [1:0] MODE_PROG = 2'b01;
    localparam logic [1:0] MODE_READ = 2'b10;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PWR_EN   = 4'd1,
        PWR_RAMP = 4'd2,
        SETUP    = 4'd3,
        SCLK_H   = 4'd4,
        SCLK_L   = 4'd5,
        HOLD     = 4'd6,
        PWR_DN   = 4'd7,
        DONE     = 4'd8
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/efuse_phase_timer.sv
// Down-counter shared by every timed sequencer phase: load (cycles-1), expire when it hits zero.
// Expire is combinational from the count so the FSM can leave a phase on its last cycle.
module efuse_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/efuse_seq_ctrl.sv
// eFuse program/read sequencer: power-switch and fuse-macro strobes for DATA_W bits, with
// DOUT read-back, busy/done handshake and invalid-mode error pulse. All outputs registered.
module efuse_seq_ctrl
    import efuse_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TCKHP_W = 4,
    parameter int T_PWR   = 8,
    parameter int T_SU    = 2,
    parameter int TCKL    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [TCKHP_W-1:0] TCKHP,
    input  logic [DATA_W-1:0]  prog,
    input  logic               DOUT,
    output logic               EN,
    output logic               RAMPENA,
    output logic               SHORT,
    output logic               CSB,
    output logic               PGM,
    output logic               SCLK,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  rdata
);

    localparam int CNT_W = $clog2(max4(T_PWR, T_SU, TCKL, 2**TCKHP_W));
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_start_q;
    logic                r_is_prog;
    logic [DATA_W-1:0]   r_prog;
    logic [TCKHP_W-1:0]  r_tckhp;
    logic [BIT_W-1:0]    r_bit;
    logic                r_smp_vld;
    logic [BIT_W-1:0]    r_smp_idx;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_en, r_rampena, r_short, r_csb, r_pgm, r_sclk;
    logic                r_busy, r_done, r_err;

    logic                w_edge, w_mode_ok, w_accept, w_expire, w_load, w_last_bit;
    logic [BIT_W-1:0]    w_bit_nxt, w_hbit;
    logic [CNT_W-1:0]    w_load_val;
    logic [TCKHP_W-1:0]  w_tckhp_cl;
    logic                w_en, w_rampena, w_short, w_csb, w_pgm, w_sclk, w_busy, w_done;

    assign w_edge     = start & ~r_start_q;
    assign w_mode_ok  = (mode == MODE_PROG) || (mode == MODE_READ);
    assign w_accept   = (r_state == IDLE) && w_edge && w_mode_ok;
    assign w_tckhp_cl = (TCKHP == '0) ? TCKHP_W'(1) : TCKHP;
    assign w_last_bit = (r_bit == BIT_W'(DATA_W - 1));
    assign w_bit_nxt  = w_last_bit ? '0 : r_bit + 1'b1;
    // Bit whose SCLK_H is being loaded: current bit from SETUP, the next one from SCLK_L.
    assign w_hbit     = (r_state == SCLK_L) ? w_bit_nxt : r_bit;

    efuse_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_val  = '0;
        w_en        = 1'b0;
        w_rampena   = 1'b0;
        w_short     = 1'b1;
        w_csb       = 1'b1;
        w_pgm       = 1'b0;
        w_sclk      = 1'b0;
        w_busy      = (r_state != IDLE);
        w_done      = 1'b0;

        case (r_state)
            IDLE:     if (w_accept) w_state_nxt = (mode == MODE_PROG) ? PWR_EN : SETUP;
            PWR_EN:   if (w_expire) w_state_nxt = PWR_RAMP;
            PWR_RAMP: if (w_expire) w_state_nxt = SETUP;
            SETUP:    if (w_expire) w_state_nxt = SCLK_H;
            SCLK_H:   if (w_expire) w_state_nxt = SCLK_L;
            SCLK_L:   if (w_expire) w_state_nxt = w_last_bit ? HOLD : SCLK_H;
            HOLD:     if (w_expire) w_state_nxt = r_is_prog ? PWR_DN : DONE;
            PWR_DN:   if (w_expire) w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            PWR_EN, PWR_RAMP, PWR_DN: w_load_val = CNT_W'(T_PWR - 1);
            SETUP, HOLD:              w_load_val = CNT_W'(T_SU - 1);
            SCLK_L:                   w_load_val = CNT_W'(TCKL - 1);
            // Unprogrammed bits still get a 1-cycle pulse so the macro address advances.
            SCLK_H:                   w_load_val = (r_is_prog && r_prog[w_hbit]) ?
                                                   CNT_W'(r_tckhp) - CNT_W'(1) : '0;
            default:                  w_load_val = '0;
        endcase

        case (r_state)
            PWR_EN, PWR_DN: begin
                w_en    = 1'b1;
                w_short = 1'b0;
            end
            PWR_RAMP: begin
                w_en      = 1'b1;
                w_short   = 1'b0;
                w_rampena = 1'b1;
            end
            SETUP, SCLK_H, SCLK_L, HOLD: begin
                w_csb  = 1'b0;
                w_sclk = (r_state == SCLK_H);
                if (r_is_prog) begin
                    w_en      = 1'b1;
                    w_short   = 1'b0;
                    w_rampena = 1'b1;
                    w_pgm     = 1'b1;
                end
            end
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    assign w_load = (w_state_nxt != r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q <= 1'b0;
            r_is_prog <= 1'b0;
            r_prog    <= '0;
            r_tckhp   <= '0;
            r_bit     <= '0;
            r_smp_vld <= 1'b0;
            r_smp_idx <= '0;
            r_rdata   <= '0;
            r_en      <= 1'b0;
            r_rampena <= 1'b0;
            r_short   <= 1'b1;
            r_csb     <= 1'b1;
            r_pgm     <= 1'b0;
            r_sclk    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start_q <= start;
            if (w_accept) begin
                r_is_prog <= (mode == MODE_PROG);
                r_prog    <= prog;
                r_tckhp   <= w_tckhp_cl;
                r_bit     <= '0;
            end else if (r_state == SCLK_L && w_expire) begin
                r_bit <= w_bit_nxt;
            end
            // Sampling is delayed one cycle to line up with the registered SCLK_L output.
            r_smp_vld <= (r_state == SCLK_L) && w_expire && !r_is_prog;
            r_smp_idx <= r_bit;
            if (r_smp_vld) begin
                r_rdata[r_smp_idx] <= DOUT;
            end
            r_en      <= w_en;
            r_rampena <= w_rampena;
            r_short   <= w_short;
            r_csb     <= w_csb;
            r_pgm     <= w_pgm;
            r_sclk    <= w_sclk;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= (r_state == IDLE) && w_edge && !w_mode_ok;
        end
    end

    assign EN      = r_en;
    assign RAMPENA = r_rampena;
    assign SHORT   = r_short;
    assign CSB     = r_csb;
    assign PGM     = r_pgm;
    assign SCLK    = r_sclk;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// Directed bench for efuse_seq_ctrl: program/read timing, SCLK pulse widths, read-back,
// invalid mode, ignored re-start and mid-operation reset.
module tb_efuse_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  TCKHP = 4'd0;
    logic [31:0] prog = 32'd0;
    logic        DOUT;
    logic        EN, RAMPENA, SHORT, CSB, PGM, SCLK, busy, done, err;
    logic [31:0] rdata;

    int n_chk = 0;
    int n_fail = 0;

    int run = 0;
    int npulse = 0;
    int hi_len[64];
    int done_cnt = 0;
    int viol = 0;
    int pwr_seen = 0;

    logic [31:0] rd_model = 32'd0;
    int          rd_cnt = 0;

    int lat;

    always #5 clk = ~clk;

    efuse_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .TCKHP   (TCKHP),
        .prog    (prog),
        .DOUT    (DOUT),
        .EN      (EN),
        .RAMPENA (RAMPENA),
        .SHORT   (SHORT),
        .CSB     (CSB),
        .PGM     (PGM),
        .SCLK    (SCLK),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata)
    );

    // Fuse macro model: address advances on each SCLK rise while selected.
    always @(posedge SCLK or posedge CSB) begin
        if (CSB) rd_cnt = 0;
        else     rd_cnt = rd_cnt + 1;
    end
    assign DOUT = (rd_cnt >= 1 && rd_cnt <= 32) ? rd_model[rd_cnt-1] : 1'b0;

    always @(negedge clk) begin
        if (SCLK) begin
            run = run + 1;
        end else if (run > 0) begin
            if (npulse < 64) hi_len[npulse] = run;
            npulse = npulse + 1;
            run = 0;
        end
        if (done) done_cnt = done_cnt + 1;
        if (PGM && CSB) viol = viol + 1;
        if (RAMPENA && !EN) viol = viol + 1;
        if (EN || RAMPENA || !SHORT) pwr_seen = pwr_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        run = 0;
        npulse = 0;
        done_cnt = 0;
        viol = 0;
        pwr_seen = 0;
        for (int i = 0; i < 64; i++) hi_len[i] = 0;
    endtask

    // Launch one operation; lat = clock edges from the edge-sample edge to done, -1 on timeout.
    task automatic run_op(input logic [1:0] m, input logic [3:0] hp, input logic [31:0] p,
                          input bit disturb, output int lat_o);
        @(negedge clk);
        clear_mon();
        mode  = m;
        TCKHP = hp;
        prog  = p;
        start = 1'b1;
        @(posedge clk);
        lat_o = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) start = 1'b0;
            if (disturb && n == 20) begin
                start = 1'b1;
                mode  = 2'b10;
                TCKHP = 4'd0;
                prog  = 32'd0;
            end
            if (done) begin
                lat_o = n;
                break;
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pwr_fuse", {EN, RAMPENA, SHORT, CSB, PGM, SCLK}, 6'b001100);
        chk("rst_handshake", {busy, done, err}, 3'b000);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Program 0x5, TCKHP=4: 8+8+2+(2*6+30*3)+2+8 = 130 phase cycles, +1 output register.
        run_op(2'b01, 4'd4, 32'h0000_0005, 1'b0, lat);
        chk("prog_latency", lat, 131);
        chk("prog_pulses", npulse, 32);
        chk("prog_hi_b0", hi_len[0], 4);
        chk("prog_hi_b1", hi_len[1], 1);
        chk("prog_hi_b2", hi_len[2], 4);
        chk("prog_hi_b31", hi_len[31], 1);
        chk("prog_done_once", done_cnt, 1);
        chk("prog_invariants", viol, 0);
        chk("prog_busy_after", busy, 1'b0);

        // Invalid mode edge while idle.
        @(negedge clk);
        clear_mon();
        mode  = 2'b11;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bad_err_pulse", {err, busy}, 2'b10);
        chk("bad_outputs", {EN, RAMPENA, SHORT, CSB, PGM, SCLK}, 6'b001100);
        @(negedge clk);
        chk("bad_err_cleared", {err, busy}, 2'b00);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("bad_no_done", done_cnt, 0);

        // Read: 2 + 32*3 + 2 = 100 phase cycles, +1.
        rd_model = 32'hA5C3_0F01;
        run_op(2'b10, 4'd4, 32'hFFFF_FFFF, 1'b0, lat);
        chk("read_latency", lat, 101);
        chk("read_rdata", rdata, 32'hA5C3_0F01);
        chk("read_pulses", npulse, 32);
        chk("read_hi_b0", hi_len[0], 1);
        chk("read_no_power", pwr_seen, 0);
        chk("read_done_once", done_cnt, 1);

        // TCKHP=0 clamps to 1: every bit is 3 cycles -> 8+8+2+96+2+8 = 124, +1.
        run_op(2'b01, 4'd0, 32'h0000_0001, 1'b0, lat);
        chk("clamp_latency", lat, 125);
        chk("clamp_hi_b0", hi_len[0], 1);
        chk("clamp_pulses", npulse, 32);
        chk("clamp_rdata_kept", rdata, 32'hA5C3_0F01);

        // Re-start and mode change mid-program must be ignored.
        run_op(2'b01, 4'd4, 32'h0000_0005, 1'b1, lat);
        chk("dist_latency", lat, 131);
        chk("dist_hi_b0", hi_len[0], 4);
        chk("dist_hi_b2", hi_len[2], 4);
        chk("dist_done_once", done_cnt, 1);
        chk("dist_invariants", viol, 0);

        // Reset during PWR_RAMP.
        @(negedge clk);
        clear_mon();
        mode  = 2'b01;
        TCKHP = 4'd4;
        prog  = 32'h0000_0005;
        start = 1'b1;
        @(posedge clk);
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("ramp_reached", {EN, RAMPENA, SHORT}, 3'b110);
        rst = 1'b1;
        @(negedge clk);
        chk("ramp_rst_outputs", {EN, RAMPENA, SHORT, CSB, PGM, SCLK, busy}, 7'b0011000);
        rst   = 1'b0;
        start = 1'b0;
        repeat (150) @(negedge clk);
        chk("ramp_rst_no_done", done_cnt, 0);
        chk("ramp_rst_rdata", rdata, 32'd0);

        rd_model = 32'h3C96_E187;
        run_op(2'b10, 4'd7, 32'd0, 1'b0, lat);
        chk("post_rst_read_latency", lat, 101);
        chk("post_rst_read_rdata", rdata, 32'h3C96_E187);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
